// File: rtl/avg_sched_pkg.sv
// rtl/avg_sched_pkg.sv - shared types, default widths and saturation helper for avg_sched
//
// Purpose: state encoding for the averaging controller, ALU op select,
//          default datapath widths and a signed saturate helper used when
//          AVG_SCHED_SAT_EN is defined.
// Ports:   none (package).
package avg_sched_pkg;

  localparam int DATAW_DEF  = 16;
  localparam int ACCW_DEF   = 32;
  localparam int N_LOG2_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SHIFT = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SHR = 1'b1
  } alu_op_t;

  // Clamp an accumulator value to the signed result range. The value is in
  // range when every bit from the result sign bit upward agrees.
  function automatic logic [DATAW_DEF-1:0] saturate(input logic [ACCW_DEF-1:0] v);
    logic [ACCW_DEF-DATAW_DEF:0] hi;
    hi = v[ACCW_DEF-1:DATAW_DEF-1];
    if ((&hi) || (~|hi)) begin
      return v[DATAW_DEF-1:0];
    end else if (v[ACCW_DEF-1]) begin
      return {1'b1, {(DATAW_DEF-1){1'b0}}};
    end else begin
      return {1'b0, {(DATAW_DEF-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/avg_sched_alu.sv
// rtl/avg_sched_alu.sv - shared signed adder / arithmetic right shifter
//
// Purpose: the single arithmetic resource time-shared by the avg_sched FSM.
// Ports:   op  - ALU_ADD: y = a + b;  ALU_SHR: y = a >>> sh
//          a   - accumulator operand (signed)
//          b   - addend (sign-extended sample)
//          sh  - unsigned shift amount
//          y   - result
module avg_sched_alu
  import avg_sched_pkg::*;
#(
  parameter int W = ACCW_DEF
) (
  input  alu_op_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [7:0]   sh,
  output logic [W-1:0] y
);

  always_comb begin
    y = a + b;
    if (op == ALU_SHR) begin
      // Shifting by the full width or more leaves only sign bits.
      if (int'(sh) >= W) begin
        y = {W{a[W-1]}};
      end else begin
        y = W'($signed(a) >>> sh);
      end
    end
  end

endmodule

// File: rtl/avg_sched.sv
// rtl/avg_sched.sv - serial shifted-sum averaging controller
//
// Purpose: accumulates N = 2**N_LOG2 signed samples through one shared
//          adder, applies N_LOG2 arithmetic shift passes of sa bits and
//          presents the result on a valid/ready output.
// Option:  AVG_SCHED_SAT_EN - saturate the result to the DATAW signed range
//          instead of truncating.
// Ports:   clk, rst (async, active low), clr (sync abort)
//          in_valid/in_ready/in_data - sample input handshake
//          sa                        - shift amount, captured with first sample
//          avg_valid/avg_ready/avg   - result output handshake
//          busy                      - controller not in IDLE
module avg_sched
  import avg_sched_pkg::*;
#(
  parameter int DATAW  = DATAW_DEF,
  parameter int ACCW   = ACCW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  input  logic [7:0]       sa,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic [DATAW-1:0] avg,
  output logic             busy
);

  localparam int N  = 1 << N_LOG2;
  localparam int CW = N_LOG2 + 1;
  localparam int PW = $clog2(N_LOG2 + 1);

  state_t           state, state_n;
  logic [ACCW-1:0]  acc;
  logic [CW-1:0]    cnt, cnt_n;
  logic [PW-1:0]    pass, pass_n;
  logic [7:0]       sa_q;
  logic             in_ready_q;
  logic             avg_valid_q;
  logic [DATAW-1:0] avg_q, avg_d;

  alu_op_t          alu_op;
  logic [ACCW-1:0]  alu_a, alu_b, alu_y;
  logic             accept;
  logic             acc_ld, acc_clr, sa_ld, avg_ld;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign avg_valid = avg_valid_q;
  assign avg       = avg_q;
  assign busy      = (state != IDLE);

  avg_sched_alu #(.W(ACCW)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .sh (sa_q),
    .y  (alu_y)
  );

`ifdef AVG_SCHED_SAT_EN
  assign avg_d = saturate(alu_y);
`else
  assign avg_d = alu_y[DATAW-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pass_n  = pass;
    alu_op  = ALU_ADD;
    alu_a   = acc;
    alu_b   = {{(ACCW-DATAW){in_data[DATAW-1]}}, in_data};
    acc_ld  = 1'b0;
    acc_clr = 1'b0;
    sa_ld   = 1'b0;
    avg_ld  = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          // First sample loads through the adder with a zero operand.
          alu_a   = '0;
          acc_ld  = 1'b1;
          sa_ld   = 1'b1;
          cnt_n   = CW'(1);
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_ld = 1'b1;
          cnt_n  = cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            pass_n  = '0;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        alu_op = ALU_SHR;
        acc_ld = 1'b1;
        pass_n = pass + PW'(1);
        if (pass == PW'(N_LOG2 - 1)) begin
          // Capture the post-shift value directly so avg is registered.
          avg_ld  = 1'b1;
          state_n = OUT;
        end
      end
      OUT: begin
        if (avg_valid_q && avg_ready) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (clr) begin
      state_n = IDLE;
      cnt_n   = '0;
      pass_n  = '0;
      acc_ld  = 1'b0;
      acc_clr = 1'b1;
      sa_ld   = 1'b0;
      avg_ld  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      cnt         <= '0;
      pass        <= '0;
      sa_q        <= '0;
      in_ready_q  <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_q       <= '0;
    end else begin
      cnt         <= cnt_n;
      pass        <= pass_n;
      in_ready_q  <= (state_n == IDLE) || (state_n == ACCUM);
      avg_valid_q <= (state_n == OUT);
      if (acc_clr) begin
        acc <= '0;
      end else if (acc_ld) begin
        acc <= alu_y;
      end
      if (sa_ld) begin
        sa_q <= sa;
      end
      if (acc_clr) begin
        avg_q <= '0;
      end else if (avg_ld) begin
        avg_q <= avg_d;
      end
    end
  end

endmodule

// File: tb/tb_avg_sched.sv
// tb/tb_avg_sched.sv - scoreboard bench for avg_sched
module tb_avg_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  sa;
  logic        avg_valid;
  logic        avg_ready;
  logic [15:0] avg;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic [15:0] sb[$];
  logic vprev = 1'b0;
  logic chk_idle = 1'b0;

  avg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sa        (sa),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .avg       (avg),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input longint sum, input int s);
    longint v;
    v = sum;
    for (int p = 0; p < 3; p++) begin
      if (s >= 32) v = (v < 0) ? -1 : 0;
      else v = v >>> s;
    end
`ifdef AVG_SCHED_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [15:0] d, input logic [7:0] s);
    logic took;
    int guard;
    guard = 0;
    took = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    sa       = s;
    while (!took && guard < 40) begin
      took = in_ready;
      step();
      guard++;
    end
    if (!took) check("accept_timeout", 0, 1);
    last_acc = cyc;
  endtask

  task automatic run_batch(input int base, input int inc, input logic [7:0] s,
                           input int count, input bit expect_out);
    longint sum;
    sum = 0;
    for (int i = 0; i < count; i++) sum += base + i * inc;
    if (expect_out) sb.push_back(model(sum, int'(s)));
    for (int i = 0; i < count; i++) push_sample(16'(base + i * inc), s);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain;
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    step();
    step();
  endtask

  task automatic wait_valid;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!avg_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!avg_valid) check("valid_timeout", 0, 1);
  endtask

  // Output monitor: latency, scoreboard pop on handshake, single-cycle valid.
  always @(negedge clk) begin
    if (rst) begin
      if (avg_valid && !vprev) check("latency", cyc - last_acc, 3);
      if (chk_idle) begin
        check("valid_oneshot", avg_valid, 0);
        check("ready_after_hs", in_ready, 1);
        chk_idle = 1'b0;
      end
      if (avg_valid && avg_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          check("avg", avg, sb.pop_front());
        end
        chk_idle = 1'b1;
      end
    end
    vprev = avg_valid;
  end

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; sa = '0; avg_ready = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_avg", avg, 0);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rdy_before_edge", in_ready, 0);
    step();
    @(negedge clk);
    check("rdy_after_edge", in_ready, 1);
    step();

    run_batch(1, 1, 8'd1, 8, 1'b1);
    wait_drain();
    run_batch(-3, 0, 8'd1, 8, 1'b1);
    wait_drain();
    run_batch(32767, 0, 8'd0, 8, 1'b1);
    wait_drain();
    run_batch(-3, 0, 8'd40, 8, 1'b1);
    wait_drain();
    run_batch(32767, 0, 8'd40, 8, 1'b1);
    wait_drain();

    // Backpressure: result held, no sample taken while in OUT.
    avg_ready = 1'b0;
    run_batch(1, 1, 8'd1, 8, 1'b1);
    wait_valid();
    step();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_avg", avg, 16'd4);
      check("bp_valid", avg_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      step();
    end
    in_valid  = 1'b0;
    avg_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("bp_idle", busy, 0);
    step();

    // Abort after five samples, colliding with a sixth.
    run_batch(1, 1, 8'd1, 5, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd6;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_busy", busy, 0);
    check("clr_ready", in_ready, 1);
    step();
    run_batch(1, 1, 8'd1, 8, 1'b1);
    wait_drain();

    // Reset during SHIFT: no result, then new sa is captured.
    run_batch(1, 1, 8'd1, 8, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_valid", avg_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_hold", avg_valid, 0);
    end
    step();
    rst = 1'b1;
    step();
    run_batch(1000, 1000, 8'd2, 8, 1'b1);
    wait_drain();

    check("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end

endmodule
